// File: rtl/regfile_scoreboard_if.sv
// ID/WB-facing bundle of the register-file scoreboard: two read ports,
// the reserve port, the writeback port and the status flags.
interface regfile_scoreboard_if #(
    parameter int RA = 4,
    parameter int DW = 32
);
    logic [RA-1:0] r0_num;
    logic [RA-1:0] r1_num;
    logic [DW-1:0] r0_data;
    logic [DW-1:0] r1_data;
    logic [1:0]    reserved;
    logic          w_reserve;
    logic [RA-1:0] w_num;
    logic          wb;
    logic [RA-1:0] wbr_num;
    logic [DW-1:0] wb_data;
    logic          busy;
    logic          err;

    modport master (
        output r0_num, r1_num, w_reserve, w_num, wb, wbr_num, wb_data,
        input  r0_data, r1_data, reserved, busy, err
    );

    modport slave (
        input  r0_num, r1_num, w_reserve, w_num, wb, wbr_num, wb_data,
        output r0_data, r1_data, reserved, busy, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register outstanding-write counters; WB data and
// WB releases are bypassed to the read ports in the same cycle.

// One architectural register: data word plus its reservation counter.
module regfile_entry #(
    parameter int DW      = 32,
    parameter int CW      = 2,
    parameter bit IS_ZERO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] data,
    output logic [CW-1:0] cnt,
    output logic          err
);
    localparam logic [CW-1:0] CMAX = '1;

    logic dec;
    assign dec = wr && (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || IS_ZERO) begin
            data <= '0;
            cnt  <= '0;
        end else begin
            if (wr) data <= wdata;
            if (inc && !dec && cnt != CMAX) cnt <= cnt + 1'b1;
            else if (dec && !inc)           cnt <= cnt - 1'b1;
        end
    end

    // Unreserved writeback, or a reserve that would wrap the counter.
    assign err = !IS_ZERO && ((wr && cnt == '0) || (inc && !dec && cnt == CMAX));
endmodule

module regfile_scoreboard #(
    parameter int NREG     = 16,
    parameter int RA       = 4,
    parameter int DW       = 32,
    parameter int CW       = 2,
    parameter int ZERO_REG = 1
) (
    input logic                clk,
    input logic                rst,
    regfile_scoreboard_if.slave bus
);
    logic [NREG-1:0][DW-1:0] regs;
    logic [NREG-1:0][CW-1:0] cnt;
    logic [NREG-1:0]         err_hit;
    logic                    err_q;

    for (genvar n = 0; n < NREG; n++) begin : g_ent
        regfile_entry #(
            .DW      (DW),
            .CW      (CW),
            .IS_ZERO ((ZERO_REG != 0) && (n == 0))
        ) u_ent (
            .clk   (clk),
            .rst   (rst),
            .inc   (bus.w_reserve && bus.w_num == RA'(n)),
            .wr    (bus.wb && bus.wbr_num == RA'(n)),
            .wdata (bus.wb_data),
            .data  (regs[n]),
            .cnt   (cnt[n]),
            .err   (err_hit[n])
        );
    end

    logic [1:0][RA-1:0] rnum;
    logic [1:0][DW-1:0] rdata;
    logic [1:0]         rres;
    logic [1:0]         whit;

    assign rnum = {bus.r1_num, bus.r0_num};

    // A writeback retiring the last reservation clears reserved this cycle.
    always_comb begin
        rdata = '0;
        rres  = '0;
        whit  = '0;
        for (int i = 0; i < 2; i++) begin
            whit[i] = bus.wb && bus.wbr_num == rnum[i];
            if (!(ZERO_REG != 0 && rnum[i] == '0)) begin
                rdata[i] = whit[i] ? bus.wb_data : regs[rnum[i]];
                rres[i]  = (cnt[rnum[i]] != '0) && !(whit[i] && cnt[rnum[i]] == CW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else if (|err_hit) err_q <= 1'b1;
    end

    assign bus.r0_data  = rdata[0];
    assign bus.r1_data  = rdata[1];
    assign bus.reserved = rres;
    assign bus.busy     = |cnt;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Random plus directed stimulus against a behavioural register-file model;
// expected read-port state is queued per cycle and checked at the falling edge.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.RA(4), .DW(32)) bus ();

    regfile_scoreboard #(
        .NREG(16), .RA(4), .DW(32), .CW(2), .ZERO_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  res;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: plain per-register outstanding-write tallies.
    logic [31:0] mreg[16];
    int          mout[16];
    bit          merr;
    bit          mvalid = 1'b0;

    function automatic logic [31:0] m_read(input int n);
        if (n == 0) return 32'h0;
        if (bus.wb && int'(bus.wbr_num) == n) return bus.wb_data;
        return mreg[n];
    endfunction

    function automatic logic m_res(input int n);
        int left;
        if (n == 0) return 1'b0;
        left = mout[n];
        if (bus.wb && int'(bus.wbr_num) == n && left > 0) left--;
        return left > 0;
    endfunction

    task automatic m_edge();
        int  old[16];
        int  wbr, wn;
        bit  dec_same;
        if (rst) begin
            for (int n = 0; n < 16; n++) begin mreg[n] = 0; mout[n] = 0; end
            merr   = 1'b0;
            mvalid = 1'b1;
            return;
        end
        old = mout;
        wbr = int'(bus.wbr_num);
        wn  = int'(bus.w_num);
        dec_same = 1'b0;
        if (bus.wb && wbr != 0) begin
            mreg[wbr] = bus.wb_data;
            if (old[wbr] == 0) merr = 1'b1;
            else begin
                mout[wbr]--;
                dec_same = (wbr == wn);
            end
        end
        if (bus.w_reserve && wn != 0) begin
            if (old[wn] == 3 && !dec_same) merr = 1'b1;
            else mout[wn]++;
        end
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        bit   b;
        b = 1'b0;
        for (int n = 0; n < 16; n++) if (mout[n] != 0) b = 1'b1;
        e.d0   = m_read(int'(bus.r0_num));
        e.d1   = m_read(int'(bus.r1_num));
        e.res  = {m_res(int'(bus.r1_num)), m_res(int'(bus.r0_num))};
        e.busy = b;
        e.err  = merr;
        return e;
    endfunction

    task automatic step(input bit r, input int a0, input int a1, input bit wr,
                        input int wn, input bit w, input int wbr, input logic [31:0] wd);
        @(posedge clk);
        m_edge();
        #1;
        rst           = r;
        bus.r0_num    = 4'(a0);
        bus.r1_num    = 4'(a1);
        bus.w_reserve = wr;
        bus.w_num     = 4'(wn);
        bus.wb        = w;
        bus.wbr_num   = 4'(wbr);
        bus.wb_data   = wd;
        if (mvalid) q.push_back(m_expect());
    endtask

    task automatic idle(input int a0, input int a1);
        step(1'b0, a0, a1, 1'b0, 0, 1'b0, 0, 32'h0);
    endtask

    task automatic reserve(input int n);
        step(1'b0, n, 0, 1'b1, n, 1'b0, 0, 32'h0);
    endtask

    task automatic wback(input int n, input logic [31:0] d);
        step(1'b0, n, 0, 1'b0, 0, 1'b1, n, d);
    endtask

    // Monitor: pops one expectation per cycle and compares all outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (bus.r0_data !== e.d0 || bus.r1_data !== e.d1 || bus.reserved !== e.res ||
                    bus.busy !== e.busy || bus.err !== e.err) begin
                    errors++;
                    $display("FAIL outputs t=%0t got d0=%h d1=%h res=%b busy=%b err=%b want d0=%h d1=%h res=%b busy=%b err=%b",
                             $time, bus.r0_data, bus.r1_data, bus.reserved, bus.busy, bus.err,
                             e.d0, e.d1, e.res, e.busy, e.err);
                end
            end
        end
    end

    initial begin
        int live[$];
        int wbr;
        bus.r0_num = '0; bus.r1_num = '0; bus.w_reserve = 1'b0; bus.w_num = '0;
        bus.wb = 1'b0; bus.wbr_num = '0; bus.wb_data = '0;

        // Reset state
        step(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 32'h0);
        idle(3, 7);
        // Reserve / release with same-cycle bypass
        reserve(5);
        idle(5, 0);
        wback(5, 32'hDEADBEEF);
        idle(5, 0);
        // Two writes in flight on one register
        reserve(2);
        reserve(2);
        wback(2, 32'h11);
        wback(2, 32'h22);
        idle(2, 5);
        // Simultaneous reserve and writeback
        reserve(4);
        step(1'b0, 4, 0, 1'b1, 4, 1'b1, 4, 32'h44);
        idle(4, 0);
        wback(4, 32'h45);
        // Unreserved writeback: sticky err
        wback(9, 32'h99);
        for (int i = 0; i < 10; i++) idle(9, 2);
        // Counter saturation
        step(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 32'h0);
        for (int i = 0; i < 4; i++) reserve(1);
        idle(1, 0);
        // Zero register
        step(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 32'h0);
        reserve(0);
        wback(0, 32'hFF);
        idle(0, 0);
        // Reset overrides concurrent reserve and writeback
        reserve(6);
        step(1'b1, 6, 6, 1'b1, 6, 1'b1, 6, 32'h66);
        idle(6, 6);

        // Randomized traffic, writebacks mostly target reserved registers
        for (int i = 0; i < 400; i++) begin
            live.delete();
            for (int n = 1; n < 16; n++) if (mout[n] != 0) live.push_back(n);
            wbr = int'($urandom_range(15));
            if (live.size() != 0 && $urandom_range(9) < 8)
                wbr = live[$urandom_range(live.size() - 1)];
            step($urandom_range(59) == 0, int'($urandom_range(15)), int'($urandom_range(15)),
                 $urandom_range(1) == 1, int'($urandom_range(15)),
                 $urandom_range(2) != 0, wbr, $urandom);
        end
        idle(0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
